// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU results, runs one outstanding load/store against
// a request/acknowledge memory port, and writes extracted load data back.
module writeback_unit (
    input  logic        clk,
    input  logic        nRST,
    input  logic        valid_in,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd_index,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        ready_in,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    output logic        reg_write,
    output logic [4:0]  write_index,
    output logic [31:0] write_data,
    output logic        misalign_err
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] MEM  = 2'b01;
    localparam logic [1:0] LWB  = 2'b10;

    // Illegal width code, store with an unsigned code, misalignment, or load+store together.
    function automatic logic access_illegal(input logic ld, input logic st,
                                            input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (ld && st) begin
            bad = 1'b1;
        end else begin
            case (f3)
                3'b000:  bad = 1'b0;
                3'b001:  bad = off[0];
                3'b010:  bad = (off != 2'b00);
                3'b100:  bad = st;
                3'b101:  bad = st | off[0];
                default: bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            2'd3:    b = rdata[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'h000000, b};
            3'b101:  res = {16'h0000, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] store_byte_en(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            3'b000:  be = 4'b0001 << off;
            3'b001:  be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] wd;
        case (f3)
            3'b000:  wd = {4{sd[7:0]}};
            3'b001:  wd = {2{sd[15:0]}};
            default: wd = sd;
        endcase
        return wd;
    endfunction

    logic [1:0]  state_q, state_d;
    logic        load_q, load_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_ren_q, mem_ren_d;
    logic        mem_wen_q, mem_wen_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_byte_en_q, mem_byte_en_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  write_index_q, write_index_d;
    logic [31:0] write_data_q, write_data_d;
    logic        misalign_err_q, misalign_err_d;

    // Next-state and output computation for the IDLE/MEM/LWB sequence.
    always_comb begin
        state_d        = state_q;
        load_d         = load_q;
        funct3_d       = funct3_q;
        off_d          = off_q;
        rd_d           = rd_q;
        rdata_d        = rdata_q;
        mem_ren_d      = mem_ren_q;
        mem_wen_d      = mem_wen_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_byte_en_d  = mem_byte_en_q;
        reg_write_d    = 1'b0;
        write_index_d  = write_index_q;
        write_data_d   = write_data_q;
        misalign_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in && (is_load || is_store)) begin
                    if (access_illegal(is_load, is_store, funct3, alu_result[1:0])) begin
                        misalign_err_d = 1'b1;
                    end else begin
                        state_d       = MEM;
                        load_d        = is_load;
                        funct3_d      = funct3;
                        off_d         = alu_result[1:0];
                        rd_d          = rd_index;
                        mem_addr_d    = {alu_result[31:2], 2'b00};
                        mem_ren_d     = is_load;
                        mem_wen_d     = is_store;
                        mem_wdata_d   = is_store ? store_wdata(funct3, store_data) : 32'h0000_0000;
                        mem_byte_en_d = is_store ? store_byte_en(funct3, alu_result[1:0]) : 4'b0000;
                    end
                end else if (valid_in && (rd_index != 5'd0)) begin
                    reg_write_d   = 1'b1;
                    write_index_d = rd_index;
                    write_data_d  = alu_result;
                end else begin
                    state_d = IDLE;
                end
            end
            MEM: begin
                if (mem_ready) begin
                    mem_ren_d = 1'b0;
                    mem_wen_d = 1'b0;
                    rdata_d   = load_q ? mem_rdata : rdata_q;
                    state_d   = load_q ? LWB : IDLE;
                end else begin
                    state_d = MEM;
                end
            end
            LWB: begin
                state_d = IDLE;
                if (rd_q != 5'd0) begin
                    reg_write_d   = 1'b1;
                    write_index_d = rd_q;
                    write_data_d  = load_extract(funct3_q, off_q, rdata_q);
                end else begin
                    reg_write_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_ren_d = 1'b0;
                mem_wen_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any outstanding request at once.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q        <= IDLE;
            load_q         <= 1'b0;
            funct3_q       <= 3'b000;
            off_q          <= 2'b00;
            rd_q           <= 5'd0;
            rdata_q        <= 32'h0000_0000;
            mem_ren_q      <= 1'b0;
            mem_wen_q      <= 1'b0;
            mem_addr_q     <= 32'h0000_0000;
            mem_wdata_q    <= 32'h0000_0000;
            mem_byte_en_q  <= 4'b0000;
            reg_write_q    <= 1'b0;
            write_index_q  <= 5'd0;
            write_data_q   <= 32'h0000_0000;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            load_q         <= load_d;
            funct3_q       <= funct3_d;
            off_q          <= off_d;
            rd_q           <= rd_d;
            rdata_q        <= rdata_d;
            mem_ren_q      <= mem_ren_d;
            mem_wen_q      <= mem_wen_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_byte_en_q  <= mem_byte_en_d;
            reg_write_q    <= reg_write_d;
            write_index_q  <= write_index_d;
            write_data_q   <= write_data_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign ready_in     = (state_q == IDLE);
    assign mem_ren      = mem_ren_q;
    assign mem_wen      = mem_wen_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_byte_en  = mem_byte_en_q;
    assign reg_write    = reg_write_q;
    assign write_index  = write_index_q;
    assign write_data   = write_data_q;
    assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus pushes expected writebacks,
// memory requests and error pulses; a negedge monitor pops and compares.
module tb_writeback_unit;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } wb_t;

    typedef struct {
        logic        ren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          cycles;
    } req_t;

    logic        clk = 1'b0;
    logic        nRST = 1'b1;
    logic        valid_in = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [4:0]  rd_index = 5'd0;
    logic [31:0] alu_result = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        ready_in, mem_ren, mem_wen, reg_write, misalign_err;
    logic [31:0] mem_addr, mem_wdata, write_data;
    logic [3:0]  mem_byte_en;
    logic [4:0]  write_index;

    int n_checks = 0;
    int n_pass   = 0;
    wb_t  wb_q[$];
    req_t req_q[$];
    bit   err_q[$];

    always #5 clk = ~clk;

    writeback_unit dut (
        .clk(clk), .nRST(nRST), .valid_in(valid_in), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .rd_index(rd_index), .alu_result(alu_result), .store_data(store_data),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .ready_in(ready_in), .mem_ren(mem_ren),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
        .reg_write(reg_write), .write_index(write_index), .write_data(write_data),
        .misalign_err(misalign_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic check_req(input req_t r);
        chk("mem_ren", {31'd0, mem_ren}, {31'd0, r.ren});
        chk("mem_wen", {31'd0, mem_wen}, {31'd0, !r.ren});
        chk("mem_addr", mem_addr, r.addr);
        if (!r.ren) begin
            chk("mem_wdata", mem_wdata, r.wdata);
            chk("mem_byte_en", {28'd0, mem_byte_en}, {28'd0, r.be});
        end
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues.
    initial begin
        req_t cur;
        wb_t  w;
        bit   active = 1'b0;
        int   cnt = 0;
        forever begin
            @(negedge clk);
            if (reg_write) begin
                if (wb_q.size() == 0) begin
                    chk("unexpected reg_write", {31'd0, reg_write}, 32'd0);
                end else begin
                    w = wb_q.pop_front();
                    chk("write_index", {27'd0, write_index}, {27'd0, w.idx});
                    chk("write_data", write_data, w.data);
                end
            end
            if (misalign_err) begin
                chk("misalign_err expected", {31'd0, misalign_err}, {31'd0, err_q.size() != 0});
                if (err_q.size() != 0) void'(err_q.pop_front());
            end
            if ((mem_ren || mem_wen) && !active) begin
                if (req_q.size() == 0) begin
                    chk("unexpected mem request", {30'd0, mem_ren, mem_wen}, 32'd0);
                end else begin
                    cur = req_q.pop_front();
                    active = 1'b1;
                    cnt = 1;
                    check_req(cur);
                end
            end else if ((mem_ren || mem_wen) && active) begin
                cnt++;
                check_req(cur);
            end else if (active) begin
                chk("request cycles", 32'(cnt), 32'(cur.cycles));
                active = 1'b0;
            end
        end
    end

    task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd);
        int n = 0;
        while (!ready_in && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_in) chk("ready_in timeout", {31'd0, ready_in}, 32'd1);
        valid_in = 1'b1; is_load = ld; is_store = st; funct3 = f3;
        rd_index = rd; alu_result = alu; store_data = sd;
        @(posedge clk); #1;
        valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0;
        alu_result = 32'hDEAD_BEEF; store_data = 32'h5A5A_5A5A;
    endtask

    task automatic respond(input int waits, input logic [31:0] rdata);
        mem_rdata = rdata;
        mem_ready = (waits == 0);
        for (int i = 0; i < waits; i++) begin
            @(posedge clk); #1;
            mem_ready = (i == waits - 1);
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_rdata = 32'h3C3C_3C3C;
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] val);
        if (rd != 5'd0) wb_q.push_back('{rd, val});
        drive_op(1'b0, 1'b0, 3'b000, rd, val, 32'h0);
    endtask

    task automatic load_op(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] rdata, input logic [31:0] expv, input int waits);
        req_q.push_back('{1'b1, {addr[31:2], 2'b00}, 32'h0, 4'h0, waits + 1});
        if (rd != 5'd0) wb_q.push_back('{rd, expv});
        drive_op(1'b1, 1'b0, f3, rd, addr, 32'h0);
        respond(waits, rdata);
    endtask

    task automatic store_op(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd,
                            input logic [3:0] be, input logic [31:0] wd, input int waits);
        req_q.push_back('{1'b0, {addr[31:2], 2'b00}, wd, be, waits + 1});
        drive_op(1'b0, 1'b1, f3, 5'd1, addr, sd);
        respond(waits, 32'h0);
    endtask

    task automatic bad_op(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] addr);
        err_q.push_back(1'b1);
        drive_op(ld, st, f3, 5'd2, addr, 32'hFFFF_FFFF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 nRST = 1'b0;
        #2;
        chk("reset ready_in", {31'd0, ready_in}, 32'd1);
        chk("reset mem_ren/wen", {30'd0, mem_ren, mem_wen}, 32'd0);
        chk("reset reg_write/err", {30'd0, reg_write, misalign_err}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        chk("reset write_data", write_data, 32'd0);
        chk("reset byte_en/index", {23'd0, mem_byte_en, write_index}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        nRST = 1'b1;
        @(posedge clk); #1;

        alu_op(5'd5, 32'h1234_5678);
        chk("ready_in after ALU", {31'd0, ready_in}, 32'd1);
        alu_op(5'd3, 32'h0000_000A);
        alu_op(5'd4, 32'h0000_000B);
        alu_op(5'd0, 32'h0000_DEAD);

        load_op(3'b000, 32'h0000_0103, 5'd7,  32'h80FF_1122, 32'hFFFF_FF80, 2);
        load_op(3'b101, 32'h0000_0202, 5'd9,  32'hBEEF_0000, 32'h0000_BEEF, 0);
        load_op(3'b001, 32'h0000_0010, 5'd10, 32'h0000_8001, 32'hFFFF_8001, 1);
        load_op(3'b100, 32'h0000_0012, 5'd11, 32'h00C3_0000, 32'h0000_00C3, 0);
        load_op(3'b010, 32'h0000_0020, 5'd12, 32'hCAFE_BABE, 32'hCAFE_BABE, 3);

        store_op(3'b000, 32'h0000_0401, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB, 1);
        store_op(3'b001, 32'h0000_0406, 32'h1234_CAFE, 4'b1100, 32'hCAFE_CAFE, 0);
        store_op(3'b010, 32'h0000_0408, 32'h1122_3344, 4'b1111, 32'h1122_3344, 2);

        bad_op(1'b1, 1'b0, 3'b010, 32'h0000_0002);
        alu_op(5'd13, 32'h0000_0055);
        bad_op(1'b0, 1'b1, 3'b100, 32'h0000_0500);
        bad_op(1'b1, 1'b1, 3'b000, 32'h0000_0600);
        bad_op(1'b1, 1'b0, 3'b001, 32'h0000_0101);
        bad_op(1'b1, 1'b0, 3'b011, 32'h0000_0000);

        load_op(3'b010, 32'h0000_0030, 5'd0, 32'h7777_7777, 32'h0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("write_index held", {27'd0, write_index}, 32'd13);
        chk("write_data held", write_data, 32'h0000_0055);

        // Abort an outstanding load with reset; nothing may retire afterwards.
        req_q.push_back('{1'b1, 32'h0000_0040, 32'h0, 4'h0, 1});
        drive_op(1'b1, 1'b0, 3'b010, 5'd14, 32'h0000_0040, 32'h0);
        @(negedge clk);
        #2 nRST = 1'b0;
        #1;
        chk("abort mem_ren", {31'd0, mem_ren}, 32'd0);
        chk("abort ready_in", {31'd0, ready_in}, 32'd1);
        chk("abort mem_addr", mem_addr, 32'd0);
        chk("abort write_index", {27'd0, write_index}, 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h9999_9999;
        repeat (2) @(posedge clk);
        #1 nRST = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        alu_op(5'd15, 32'h0000_0077);
        repeat (5) @(posedge clk);
        #1;
        chk("pending writebacks", 32'(wb_q.size()), 32'd0);
        chk("pending requests", 32'(req_q.size()), 32'd0);
        chk("pending misalign pulses", 32'(err_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
